// File: rtl/dsa_pkg.sv
// Shared types and helpers for the digit-serial adder.
// State encoding, operation codes and a width helper for the digit counter.
package dsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bits needed to count 0..value-1, never less than one so a
  // single-digit configuration still has a legal counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
// c_msb exposes the carry into the top bit so the caller can form the
// two's-complement overflow flag on the most significant digit.
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial WIDTH-bit add/subtract with valid/ready handshakes.
// Processes DIGIT bits per clock, LSB digit first; results are registered
// and held until the next operation completes.
// Optional accumulator operand: define DIGIT_SERIAL_ADDER_ACCUM_EN.
module digit_serial_adder
  import dsa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = clog2(NDIG);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res, a_src;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] d_s;
  logic             d_co, d_cmsb;
  logic             accept, last_digit;

  assign accept     = in_valid && in_ready;
  assign last_digit = (cnt == CW'(NDIG - 1));

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x     (sa[DIGIT-1:0]),
    .y     (sb[DIGIT-1:0]),
    .ci    (carry),
    .s     (d_s),
    .co    (d_co),
    .c_msb (d_cmsb)
  );

`ifdef DIGIT_SERIAL_ADDER_ACCUM_EN
  logic [WIDTH-1:0] acc;

  assign a_src = acc_sel ? acc : a;

  // Accumulator follows every delivered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (out_valid && out_ready) begin
      acc <= sum;
    end
  end
`else
  logic unused_acc_sel;

  assign a_src          = a;
  assign unused_acc_sel = acc_sel;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept, walk NDIG digits, hold until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_digit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is also masked while reset is held.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Operand shift registers, running carry, result assembly and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        sa    <= a_src;
        sb    <= (op_sub == OP_SUB) ? ~b : b;
        carry <= (op_sub == OP_SUB) ? 1'b1 : cin;
        cnt   <= '0;
      end
    end else if (state == RUN) begin
      sa    <= sa >> DIGIT;
      sb    <= sb >> DIGIT;
      res   <= WIDTH'({d_s, res} >> DIGIT);
      carry <= d_co;
      cnt   <= cnt + CW'(1);
      if (last_digit) begin
        sum  <= WIDTH'({d_s, res} >> DIGIT);
        cout <= d_co;
        ovf  <= d_co ^ d_cmsb;
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: one WIDTH=8 instance per DIGIT
// setting (1, 2, 4, 8) driven in lockstep from shared stimulus.
`timescale 1ns/1ps
module tb_digit_serial_adder;

  localparam int NDG [4] = '{8, 4, 2, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       op_sub = 1'b0;
  logic       acc_sel = 1'b0;
  logic       out_ready = 1'b0;

  logic [3:0]      in_ready_w, out_valid_w, cout_w, ovf_w;
  logic [3:0][7:0] sum_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub), .acc_sel(acc_sel),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .sum(sum_w[0]),
    .cout(cout_w[0]), .ovf(ovf_w[0]));

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub), .acc_sel(acc_sel),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .sum(sum_w[1]),
    .cout(cout_w[1]), .ovf(ovf_w[1]));

  digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub), .acc_sel(acc_sel),
    .out_valid(out_valid_w[2]), .out_ready(out_ready), .sum(sum_w[2]),
    .cout(cout_w[2]), .ovf(ovf_w[2]));

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[3]),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub), .acc_sel(acc_sel),
    .out_valid(out_valid_w[3]), .out_ready(out_ready), .sum(sum_w[3]),
    .cout(cout_w[3]), .ovf(ovf_w[3]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, sum[7:0]}
  function automatic logic [9:0] gold(input logic [7:0] x, input logic [7:0] y,
                                      input logic c, input logic s);
    logic [7:0] yy;
    logic [8:0] f;
    logic       o;
    yy = s ? ~y : y;
    f  = {1'b0, x} + {1'b0, yy} + (s ? 9'd1 : {8'd0, c});
    o  = (x[7] == yy[7]) && (f[7] != x[7]);
    return {o, f};
  endfunction

  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tcin, input logic tsub, input logic tacc,
                        input logic [7:0] es, input logic ec, input logic eo);
    int lat [4];
    chk({tag, " in_ready before"}, 32'(in_ready_w[1]), 32'd1);
    a = ta; b = tb_; cin = tcin; op_sub = tsub; acc_sel = tacc;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int d = 0; d < 4; d++) lat[d] = 0;
    for (int k = 1; k <= 12; k++) begin
      tick;
      for (int d = 0; d < 4; d++)
        if (out_valid_w[d] && lat[d] == 0) lat[d] = k;
    end
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s latency d%0d", tag, d), 32'(lat[d]), 32'(NDG[d]));
      chk($sformatf("%s out_valid d%0d", tag, d), 32'(out_valid_w[d]), 32'd1);
      chk($sformatf("%s sum d%0d", tag, d), 32'(sum_w[d]), 32'(es));
      chk($sformatf("%s cout d%0d", tag, d), 32'(cout_w[d]), 32'(ec));
      chk($sformatf("%s ovf d%0d", tag, d), 32'(ovf_w[d]), 32'(eo));
    end
    chk({tag, " in_ready busy"}, 32'(in_ready_w[1]), 32'd0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, " out_valid after hs"}, 32'(out_valid_w), 32'd0);
    chk({tag, " in_ready after hs"}, 32'(in_ready_w), 32'hF);
    chk({tag, " sum hold"}, 32'(sum_w[1]), 32'(es));
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc, rs;
    logic [9:0] g;

    // Reset state
    tick;
    chk("reset in_ready", 32'(in_ready_w), 32'd0);
    chk("reset out_valid", 32'(out_valid_w), 32'd0);
    chk("reset sum", 32'(sum_w), 32'd0);
    chk("reset cout", 32'(cout_w), 32'd0);
    chk("reset ovf", 32'(ovf_w), 32'd0);
    rst = 1'b0;
    tick;
    chk("idle in_ready", 32'(in_ready_w), 32'hF);

    // Directed arithmetic
    run_op("add_wrap",  8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub_neg",   8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    run_op("sub_ovf",   8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    run_op("add_cin",   8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 8'h31, 1'b0, 1'b0);
    run_op("sub_cin_x", 8'h09, 8'h03, 1'b1, 1'b1, 1'b0, 8'h06, 1'b1, 1'b0);

    // Backpressure: result held, second operand beat refused
    a = 8'h12; b = 8'h34; cin = 1'b0; op_sub = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 5) begin
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      end
      tick;
      if (k >= 4) begin
        chk($sformatf("bp out_valid c%0d", k), 32'(out_valid_w[1]), 32'd1);
        chk($sformatf("bp sum c%0d", k), 32'(sum_w[1]), 32'h46);
        chk($sformatf("bp in_ready c%0d", k), 32'(in_ready_w[1]), 32'd0);
      end
    end
    chk("bp sum d1", 32'(sum_w[0]), 32'h46);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("bp released out_valid", 32'(out_valid_w), 32'd0);
    chk("bp released in_ready", 32'(in_ready_w), 32'hF);
    in_valid = 1'b0;
    tick;
    chk("bp no second accept", 32'(out_valid_w), 32'd0);
    chk("bp still idle", 32'(in_ready_w), 32'hF);

    // Reset in the second RUN cycle
    a = 8'h55; b = 8'h22; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(out_valid_w), 32'd0);
    chk("midrst sum", 32'(sum_w), 32'd0);
    chk("midrst cout", 32'(cout_w), 32'd0);
    chk("midrst ovf", 32'(ovf_w), 32'd0);
    chk("midrst in_ready", 32'(in_ready_w), 32'd0);
    tick;
    rst = 1'b0;
    tick;
    chk("midrst no result", 32'(out_valid_w), 32'd0);
    run_op("post_rst", 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

    // Random vectors against the reference
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      g  = gold(ra, rb, rc, rs);
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, 1'b0, g[7:0], g[8], g[9]);
    end

`ifdef DIGIT_SERIAL_ADDER_ACCUM_EN
    // Accumulator chaining
    run_op("acc0", 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0);
    run_op("acc1", 8'h77, 8'h03, 1'b0, 1'b0, 1'b1, 8'h08, 1'b0, 1'b0);
    run_op("acc2", 8'h77, 8'hFA, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
`else
    // acc_sel has no effect without the accumulator
    run_op("acc0", 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0);
    run_op("acc_ign", 8'h40, 8'h03, 1'b0, 1'b0, 1'b1, 8'h43, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
